// File: rtl/robo_pkg.sv
// rtl/robo_pkg.sv - shared state encoding, burst lengths and maze constants for robo_ctrl
package robo_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SENSE,
    ST_FWD,
    ST_TURN_L,
    ST_TURN_R,
    ST_REMOVE,
    ST_WAIT,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam int unsigned REMOVE_CYCLES_DEF = 3;
  localparam int unsigned TURN_R_CYCLES     = 3;

  // Cell codes and headings used by the robot/maze model; headings listed in CCW order
  typedef enum logic [1:0] {CELL_FREE, CELL_WALL, CELL_BLACK, CELL_BARRIER} cell_e;
  typedef enum logic [1:0] {DIR_N, DIR_W, DIR_S, DIR_E} dir_e;

  function automatic dir_e rotate_ccw(input dir_e d);
    return dir_e'(2'(d + 2'd1));
  endfunction

  // The burst timer counts down to zero, so an N-cycle burst loads N-1
  function automatic logic [1:0] burst_load(input int unsigned cycles);
    return 2'(cycles - 1);
  endfunction

endpackage

// File: rtl/robo_cmd_timer.sv
// rtl/robo_cmd_timer.sv - 2-bit down counter timing multi-cycle command bursts
module robo_cmd_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic       zero_o
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 2'd0);

endmodule

// File: rtl/robo_ctrl.sv
// rtl/robo_ctrl.sv - left-hand wall-follower controller with registered robot commands
module robo_ctrl
  import robo_pkg::*;
#(
  parameter logic [15:0] MAX_STEPS     = 16'hFFFF,
  parameter int unsigned REMOVE_CYCLES = REMOVE_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        head_in,
  input  logic        left_in,
  input  logic        under_in,
  input  logic        barrier_in,
  output logic        avancar,
  output logic        girar,
  output logic        remover,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] step_count
);

  localparam logic [1:0] REMOVE_LOAD = burst_load(REMOVE_CYCLES);
  localparam logic [1:0] TURN_R_LOAD = burst_load(TURN_R_CYCLES);

  state_e      state_q;
  state_e      sense_next;
  logic        turned_left_q;
  logic [15:0] step_q;
  logic        avancar_q, girar_q, remover_q;
  logic        busy_q, done_q, fail_q;
  logic        timer_load, timer_zero;
  logic [1:0]  timer_val;

  always_comb begin
    sense_next = ST_TURN_R;
    if (under_in) begin
      sense_next = ST_DONE;
    end else if (!left_in && !turned_left_q) begin
      sense_next = ST_TURN_L;
    end else if (barrier_in) begin
      sense_next = ST_REMOVE;
    end else if (!head_in) begin
      sense_next = ST_FWD;
    end
  end

  // Timer is armed on the SENSE edge so the burst length counts from the first command cycle
  assign timer_load = (state_q == ST_SENSE) &&
                      ((sense_next == ST_TURN_R) || (sense_next == ST_REMOVE));
  assign timer_val  = (sense_next == ST_REMOVE) ? REMOVE_LOAD : TURN_R_LOAD;

  robo_cmd_timer u_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      turned_left_q <= 1'b0;
      step_q        <= 16'd0;
      avancar_q     <= 1'b0;
      girar_q       <= 1'b0;
      remover_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      remover_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            state_q       <= ST_SENSE;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            step_q        <= 16'd0;
            turned_left_q <= 1'b0;
          end
        end
        ST_SENSE: begin
          state_q <= sense_next;
          case (sense_next)
            ST_DONE: begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
            ST_TURN_L: begin
              girar_q       <= 1'b1;
              turned_left_q <= 1'b1;
            end
            ST_REMOVE: remover_q <= 1'b1;
            ST_FWD: begin
              avancar_q     <= 1'b1;
              turned_left_q <= 1'b0;
              if (step_q != 16'hFFFF) step_q <= step_q + 16'd1;
            end
            default: begin
              girar_q       <= 1'b1;
              turned_left_q <= 1'b0;
            end
          endcase
        end
        ST_FWD: begin
          if (step_q >= MAX_STEPS) begin
            state_q <= ST_FAIL;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_TURN_L: state_q <= ST_WAIT;
        ST_TURN_R: begin
          if (timer_zero) state_q <= ST_WAIT;
          else            girar_q <= 1'b1;
        end
        ST_REMOVE: begin
          if (timer_zero) state_q   <= ST_WAIT;
          else            remover_q <= 1'b1;
        end
        ST_WAIT: state_q <= ST_SENSE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avancar    = avancar_q;
  assign girar      = girar_q;
  assign remover    = remover_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_robo_ctrl.sv
// tb/tb_robo_ctrl.sv - scoreboard bench for robo_ctrl with directed sensor scenarios
`timescale 1ns/1ps
module tb_robo_ctrl;

  localparam int K_AV   = 0;
  localparam int K_GI   = 1;
  localparam int K_RM   = 2;
  localparam int K_DONE = 3;
  localparam int K_FAIL = 4;

  typedef struct {
    int kind;
    int rel;
    int steps;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        head_in = 1'b0;
  logic        left_in = 1'b1;
  logic        under_in = 1'b0;
  logic        barrier_in = 1'b0;
  logic        avancar, girar, remover, busy, done, fail;
  logic [15:0] step_count;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  ev_t  exp_q[$];
  logic done_prev = 1'b0;
  logic fail_prev = 1'b0;

  robo_ctrl #(.MAX_STEPS(16'd4), .REMOVE_CYCLES(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .head_in    (head_in),
    .left_in    (left_in),
    .under_in   (under_in),
    .barrier_in (barrier_in),
    .avancar    (avancar),
    .girar      (girar),
    .remover    (remover),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .step_count (step_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic expect_ev(input int kind, input int rel, input int steps);
    ev_t e;
    e.kind = kind;
    e.rel = rel;
    e.steps = steps;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int rel, input int steps);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got kind=%0d rel=%0d steps=%0d, expected none", kind, rel, steps);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.rel == rel && e.steps == steps) n_pass++;
      else $display("FAIL event: got kind=%0d rel=%0d steps=%0d, expected kind=%0d rel=%0d steps=%0d",
                    kind, rel, steps, e.kind, e.rel, e.steps);
    end
  endtask

  always @(negedge clock) begin
    if (avancar) got_ev(K_AV, cyc - start_cyc, int'(step_count));
    if (girar)   got_ev(K_GI, cyc - start_cyc, int'(step_count));
    if (remover) got_ev(K_RM, cyc - start_cyc, int'(step_count));
    if (done && !done_prev) got_ev(K_DONE, cyc - start_cyc, int'(step_count));
    if (fail && !fail_prev) got_ev(K_FAIL, cyc - start_cyc, int'(step_count));
    if ((int'(avancar) + int'(girar) + int'(remover)) > 1)
      check("one_cmd", int'(avancar) + int'(girar) + int'(remover), 1);
    done_prev = done;
    fail_prev = fail;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - start_cyc < r) tick();
  endtask

  task automatic do_reset(input string tag);
    check({tag, "_missing"}, exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check({tag, "_rst_cmds"}, int'({avancar, girar, remover}), 0);
    check({tag, "_rst_status"}, int'({busy, done, fail}), 0);
    check({tag, "_rst_steps"}, int'(step_count), 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check({tag, "_idle"}, int'({busy, done, fail}), 0);
  endtask

  function automatic void set_sensors(input logic h, input logic l, input logic b, input logic u);
    head_in = h;
    left_in = l;
    barrier_in = b;
    under_in = u;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    check("por_cmds", int'({avancar, girar, remover}), 0);
    check("por_status", int'({busy, done, fail}), 0);
    check("por_steps", int'(step_count), 0);
    reset = 1'b1;
    repeat (3) tick();
    check("idle_no_start", int'({busy, done, fail}), 0);

    // Open corridor: advance every 3 cycles
    set_sensors(1'b0, 1'b1, 1'b0, 1'b0);
    expect_ev(K_AV, 2, 1);
    expect_ev(K_AV, 5, 2);
    expect_ev(K_AV, 8, 3);
    pulse_start();
    wait_rel(10);
    check("corridor_steps", int'(step_count), 3);
    do_reset("corridor");

    // Left opening: one left turn, then forward before turning left again
    set_sensors(1'b0, 1'b0, 1'b0, 1'b0);
    expect_ev(K_GI, 2, 0);
    expect_ev(K_AV, 5, 1);
    expect_ev(K_GI, 8, 1);
    pulse_start();
    wait_rel(9);
    do_reset("left");

    // Dead end: 3-cycle right-turn bursts every 5 cycles, reset mid-burst
    set_sensors(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) expect_ev(K_GI, 2 + 5 * i + j, 0);
    pulse_start();
    wait_rel(12);
    do_reset("right");

    // Three barrier levels, then forward
    set_sensors(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) expect_ev(K_RM, 2 + 5 * i + j, 0);
    expect_ev(K_AV, 17, 1);
    pulse_start();
    wait_rel(15);
    barrier_in = 1'b0;
    wait_rel(19);
    do_reset("barrier");

    // Reset in the middle of a remover burst
    set_sensors(1'b0, 1'b1, 1'b1, 1'b0);
    expect_ev(K_RM, 2, 0);
    pulse_start();
    wait_rel(3);
    check("pre_rst_remover", int'(remover), 1);
    do_reset("mid_remove");

    // Black cell under the robot
    set_sensors(1'b0, 1'b1, 1'b0, 1'b1);
    expect_ev(K_DONE, 2, 0);
    pulse_start();
    wait_rel(6);
    check("done_status", int'({busy, done, fail}), 2);
    do_reset("done");

    // Step limit of 4 reached in an open corridor
    set_sensors(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) expect_ev(K_AV, 2 + 3 * i, i + 1);
    expect_ev(K_FAIL, 12, 4);
    pulse_start();
    wait_rel(14);
    check("fail_status", int'({busy, done, fail}), 1);
    check("fail_steps", int'(step_count), 4);
    check("fail_missing", exp_q.size(), 0);

    // Restart straight from FAIL clears the step count
    expect_ev(K_AV, 2, 1);
    pulse_start();
    wait_rel(4);
    check("restart_status", int'({busy, done, fail}), 4);
    check("restart_steps", int'(step_count), 1);
    do_reset("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
